// File: rtl/axi_defs.sv
// ---------------------------------------------------------------------------
// axi_defs
//   Shared definitions for the CPU-side SRAM-like to AXI responders.
//   Holds the responder FSM encoding, the AXI size and burst codes, the fixed
//   transaction IDs for the instruction and data ports, and a helper that
//   maps the datapath size code onto the AXI AxSIZE field.
//   The package has no ports.
// ---------------------------------------------------------------------------
package axi_defs;

    // Responder FSM encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_ADDR = 3'd1;
    localparam logic [2:0] ST_RD_DATA = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_RESP = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        RD_ADDR = ST_RD_ADDR,
        RD_DATA = ST_RD_DATA,
        WR_REQ  = ST_WR_REQ,
        WR_RESP = ST_WR_RESP,
        DONE    = ST_DONE
    } respState_e;

    // AXI AxSIZE codes (bytes per beat = 2**AxSIZE)
    localparam logic [2:0] AXI_SIZE_BYTE = 3'b000;
    localparam logic [2:0] AXI_SIZE_HALF = 3'b001;
    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    // AXI AxBURST code for incrementing bursts
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Fixed transaction IDs for the two CPU ports
    localparam logic [3:0] AXI_ID_INST = 4'b0000;
    localparam logic [3:0] AXI_ID_DATA = 4'b0001;

    // The datapath size code (0 byte, 1 half, 2 word) already matches the
    // low bits of AxSIZE; widening it keeps the mapping in one place.
    function automatic logic [2:0] axiSize(input logic [1:0] memSize);
        return {1'b0, memSize};
    endfunction

endpackage

// File: rtl/data_axi_responder.sv
// ---------------------------------------------------------------------------
// data_axi_responder
//   Turns one SRAM-like request from the CPU memory stage into one single-beat
//   AXI read or write and freezes the pipeline until that transaction has
//   completed. The instruction side uses another instance with AXI_ID set to
//   AXI_ID_INST.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset shared with the
//                    interconnect
//   mem_en           request valid (already masked by exception flush)
//   mem_wen[3:0]     byte enables; nonzero means write, zero means read
//   mem_size[1:0]    0 byte, 1 half, 2 word
//   mem_addr         byte address, forwarded unmodified to the bus
//   mem_wdata        write data, already lane-aligned
//   longest_stall    global pipeline freeze from the hazard unit
//   mem_rdata        registered read result, held until the next read
//   stall_from_mem   request in progress (combinational)
//   ar*/r*           AXI read address / read data channels
//   aw*/w*/b*        AXI write address / write data / write response channels
// ---------------------------------------------------------------------------
module data_axi_responder
    import axi_defs::*;
#(
    parameter logic [3:0] AXI_ID = AXI_ID_DATA,
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Datapath memory-stage interface
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              longest_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_from_mem,

    // AXI read address channel
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,

    // AXI read data channel
    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    // AXI write address channel
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,

    // AXI write data channel
    output logic [3:0]        wid,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,

    // AXI write response channel
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    respState_e        state;

    // Request fields captured in IDLE; the bus sees these, never the live
    // datapath inputs, so a flush mid-transaction cannot corrupt it.
    logic [ADDR_W-1:0] latchedAddr;
    logic [1:0]        latchedSize;
    logic [DATA_W-1:0] latchedWdata;
    logic [3:0]        latchedWen;

    // AW and W complete independently; each flag remembers its handshake.
    logic              awDone;
    logic              wDone;
    logic              awDoneNext;
    logic              wDoneNext;

    // Response IDs, error codes and rlast are intentionally not acted on:
    // every transaction is single-beat and bus errors raise no exception.
    logic              unusedSignals;
    assign unusedSignals = ^{rid, rresp, rlast, bid, bresp};

    // Handshake outcome of the current cycle folded into the done flags, so
    // that AW and W completing on the same edge moves straight to WR_RESP.
    assign awDoneNext = awDone | (awvalid & awready);
    assign wDoneNext  = wDone  | (wvalid  & wready);

    // Freeze the pipeline in the request cycle itself, and release it in
    // DONE so the stage can advance while the result is presented.
    assign stall_from_mem = ((state == IDLE) && mem_en) ||
                            ((state != IDLE) && (state != DONE));

    // Fixed single-beat fields
    assign arid   = AXI_ID;
    assign awid   = AXI_ID;
    assign wid    = AXI_ID;
    assign arlen  = 8'd0;
    assign awlen  = 8'd0;
    assign wlast  = 1'b1;
    assign araddr = latchedAddr;
    assign awaddr = latchedAddr;
    assign arsize = axiSize(latchedSize);
    assign awsize = axiSize(latchedSize);
    assign wdata  = latchedWdata;
    assign wstrb  = latchedWen;

    // NOTE: state and every registered output use non-blocking assignments so
    // all of them update together from the values sampled at this clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data-path registers are reset too, not just the
            // control state: mem_rdata and the latched fields must read as
            // zero after reset, including a reset that hits mid-transaction.
            state        <= IDLE;
            arvalid      <= 1'b0;
            rready       <= 1'b0;
            awvalid      <= 1'b0;
            wvalid       <= 1'b0;
            bready       <= 1'b0;
            awDone       <= 1'b0;
            wDone        <= 1'b0;
            latchedAddr  <= '0;
            latchedSize  <= '0;
            latchedWdata <= '0;
            latchedWen   <= '0;
            mem_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        latchedAddr <= mem_addr;
                        latchedSize <= mem_size;
                        if (mem_wen == 4'b0000) begin
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end else begin
                            latchedWdata <= mem_wdata;
                            latchedWen   <= mem_wen;
                            awvalid      <= 1'b1;
                            wvalid       <= 1'b1;
                            awDone       <= 1'b0;
                            wDone        <= 1'b0;
                            state        <= WR_REQ;
                        end
                    end
                end

                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (rvalid) begin
                        mem_rdata <= rdata;
                        rready    <= 1'b0;
                        state     <= DONE;
                    end
                end

                WR_REQ: begin
                    // Each valid drops on its own handshake and is never
                    // re-raised for this request.
                    if (awready) begin
                        awvalid <= 1'b0;
                    end
                    if (wready) begin
                        wvalid <= 1'b0;
                    end
                    awDone <= awDoneNext;
                    wDone  <= wDoneNext;
                    if (awDoneNext && wDoneNext) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    // While frozen the same request is still on mem_en, so
                    // only leave once the pipeline has actually advanced.
                    if (!longest_stall) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_axi_responder.sv
// ---------------------------------------------------------------------------
// tb_data_axi_responder
//   Self-checking bench for data_axi_responder. A cycle-based AXI slave with
//   programmable per-channel delays answers the DUT and logs what it saw;
//   each request pushes its expected outcome onto a queue that is popped and
//   compared when the DUT releases the stall.
// ---------------------------------------------------------------------------
module tb_data_axi_responder;

    logic        clk;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        longest_stall;
    logic [31:0] mem_rdata;
    logic        stall_from_mem;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    data_axi_responder #(
        .AXI_ID (4'b0001),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_en         (mem_en),
        .mem_wen        (mem_wen),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .longest_stall  (longest_stall),
        .mem_rdata      (mem_rdata),
        .stall_from_mem (stall_from_mem),
        .arid           (arid),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arvalid        (arvalid),
        .arready        (arready),
        .rid            (rid),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .rvalid         (rvalid),
        .rready         (rready),
        .awid           (awid),
        .awaddr         (awaddr),
        .awlen          (awlen),
        .awsize         (awsize),
        .awvalid        (awvalid),
        .awready        (awready),
        .wid            (wid),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .wlast          (wlast),
        .wvalid         (wvalid),
        .wready         (wready),
        .bid            (bid),
        .bresp          (bresp),
        .bvalid         (bvalid),
        .bready         (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int nAssert = 0;
    int nFail   = 0;

    task automatic assertEqual(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAssert++;
        if (observed !== expected) begin
            nFail++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // ---------------- slave model ----------------
    int          arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
    int          arWait = 0, rWait = 0, awWait = 0, wWait = 0, bWait = 0;
    bit          pendingR = 0, pendingB = 0, gotAw = 0, gotW = 0;
    int          arCount = 0, rCount = 0, awCount = 0, wCount = 0, bCount = 0;
    int          cycle = 0, arStartCycle = 0, bHsCycle = 0;
    logic [31:0] rdataResp = '0;
    logic [31:0] obsAraddr, obsArsize, obsArlen, obsArid;
    logic [31:0] obsAwaddr, obsAwsize, obsAwlen, obsAwid;
    logic [31:0] obsWdata, obsWstrb, obsWlast, obsWid;

    // Runs once per cycle just after the rising edge. Responses (R, B) are
    // evaluated before requests so a response is never offered in the same
    // cycle as the request that caused it.
    task automatic slaveStep();
        cycle++;
        if (rst) begin
            arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
            arWait = 0; rWait = 0; awWait = 0; wWait = 0; bWait = 0;
            pendingR = 0; pendingB = 0; gotAw = 0; gotW = 0;
            return;
        end
        rdata  = rdataResp;
        rvalid = 1'b0;
        if (pendingR) begin
            rvalid = (rWait >= rDelay);
            rWait++;
            if (rvalid && rready) begin
                pendingR = 0;
                rCount++;
            end
        end
        bvalid = 1'b0;
        if (pendingB) begin
            bvalid = (bWait >= bDelay);
            bWait++;
            if (bvalid && bready) begin
                pendingB = 0;
                bCount++;
                bHsCycle = cycle;
            end
        end
        arready = 1'b0;
        if (arvalid) begin
            if (arWait == 0) arStartCycle = cycle;
            arready = (arWait >= arDelay);
            arWait++;
            if (arready) begin
                arCount++;
                obsAraddr = araddr;
                obsArsize = 32'(arsize);
                obsArlen  = 32'(arlen);
                obsArid   = 32'(arid);
                pendingR  = 1;
                rWait     = 0;
                arWait    = 0;
            end
        end else begin
            arWait = 0;
        end
        awready = 1'b0;
        if (awvalid) begin
            awready = (awWait >= awDelay);
            awWait++;
            if (awready) begin
                awCount++;
                obsAwaddr = awaddr;
                obsAwsize = 32'(awsize);
                obsAwlen  = 32'(awlen);
                obsAwid   = 32'(awid);
                gotAw     = 1;
                awWait    = 0;
            end
        end else begin
            awWait = 0;
        end
        wready = 1'b0;
        if (wvalid) begin
            wready = (wWait >= wDelay);
            wWait++;
            if (wready) begin
                wCount++;
                obsWdata = wdata;
                obsWstrb = 32'(wstrb);
                obsWlast = 32'(wlast);
                obsWid   = 32'(wid);
                gotW     = 1;
                wWait    = 0;
            end
        end else begin
            wWait = 0;
        end
        if (gotAw && gotW) begin
            pendingB = 1;
            bWait    = 0;
            gotAw    = 0;
            gotW     = 0;
        end
    endtask

    initial begin
        rid = 4'h0; rresp = 2'b00; rlast = 1'b1; bid = 4'h0; bresp = 2'b00;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            slaveStep();
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          isWr;
        logic [31:0] addr;
        logic [31:0] axSize;
        logic [31:0] wstrbExp;
        logic [31:0] wdataExp;
        logic [31:0] rdataExp;
        int          stallExp;
    } txn_t;

    txn_t        expQ[$];
    logic [31:0] modelRdata = '0;

    // One request from the datapath. holdDone > 0 keeps longest_stall high
    // for that many DONE cycles before letting the pipeline advance.
    task automatic runRequest(input bit isWr, input logic [31:0] addr,
                              input logic [1:0] size, input logic [3:0] wen,
                              input logic [31:0] wd, input logic [31:0] resp,
                              input int holdDone);
        txn_t t;
        int   ar0, aw0, w0, b0, stallCycles;
        t.isWr     = isWr;
        t.addr     = addr;
        t.axSize   = {30'd0, size};
        t.wstrbExp = {28'd0, wen};
        t.wdataExp = wd;
        t.rdataExp = isWr ? modelRdata : resp;
        t.stallExp = isWr ? 3 + ((awDelay > wDelay) ? awDelay : wDelay) + bDelay
                          : 3 + arDelay + rDelay;
        modelRdata = t.rdataExp;
        expQ.push_back(t);

        ar0 = arCount; aw0 = awCount; w0 = wCount; b0 = bCount;
        rdataResp     = resp;
        mem_en        = 1'b1;
        mem_wen       = isWr ? wen : 4'b0000;
        mem_size      = size;
        mem_addr      = addr;
        mem_wdata     = wd;
        longest_stall = (holdDone > 0);

        stallCycles = 0;
        @(negedge clk);
        while (stall_from_mem && stallCycles < 200) begin
            stallCycles++;
            @(negedge clk);
        end

        t = expQ.pop_front();
        assertEqual("stallCycles", stallCycles, t.stallExp);
        assertEqual("rdataInDone", mem_rdata, t.rdataExp);
        if (t.isWr) begin
            assertEqual("awCount", awCount - aw0, 1);
            assertEqual("wCount", wCount - w0, 1);
            assertEqual("bCount", bCount - b0, 1);
            assertEqual("arCountOnWrite", arCount - ar0, 0);
            assertEqual("awaddr", obsAwaddr, t.addr);
            assertEqual("awsize", obsAwsize, t.axSize);
            assertEqual("awlen", obsAwlen, 0);
            assertEqual("awid", obsAwid, 1);
            assertEqual("wdata", obsWdata, t.wdataExp);
            assertEqual("wstrb", obsWstrb, t.wstrbExp);
            assertEqual("wlast", obsWlast, 1);
            assertEqual("wid", obsWid, 1);
        end else begin
            assertEqual("arCount", arCount - ar0, 1);
            assertEqual("awCountOnRead", awCount - aw0, 0);
            assertEqual("araddr", obsAraddr, t.addr);
            assertEqual("arsize", obsArsize, t.axSize);
            assertEqual("arlen", obsArlen, 0);
            assertEqual("arid", obsArid, 1);
        end

        if (holdDone > 0) begin
            for (int i = 1; i < holdDone; i++) begin
                @(posedge clk);
                #1;
                @(negedge clk);
                assertEqual("holdStall", 32'(stall_from_mem), 0);
                assertEqual("holdArvalid", 32'(arvalid), 0);
                assertEqual("holdRdata", mem_rdata, t.rdataExp);
            end
            @(posedge clk);
            #1;
            longest_stall = 1'b0;
            @(negedge clk);
            assertEqual("releaseStall", 32'(stall_from_mem), 0);
            assertEqual("holdArCount", arCount - ar0, 1);
        end
        @(posedge clk);
        #1;
        mem_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int waitCnt;
        rst = 1'b1; mem_en = 0; mem_wen = 0; mem_size = 0; mem_addr = 0;
        mem_wdata = 0; longest_stall = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        assertEqual("rstArvalid", 32'(arvalid), 0);
        assertEqual("rstAwvalid", 32'(awvalid), 0);
        assertEqual("rstWvalid", 32'(wvalid), 0);
        assertEqual("rstRready", 32'(rready), 0);
        assertEqual("rstBready", 32'(bready), 0);
        assertEqual("rstStall", 32'(stall_from_mem), 0);
        assertEqual("rstRdata", mem_rdata, 0);
        assertEqual("rstAraddr", araddr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle: no requests, no bus activity
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            assertEqual("idleValids", {29'd0, arvalid, awvalid, wvalid}, 0);
            assertEqual("idleStall", 32'(stall_from_mem), 0);
        end
        @(posedge clk);
        #1;

        // Word read, zero-wait slave
        runRequest(0, 32'hBFC0_0100, 2'd2, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0);

        // Byte write, W accepted two cycles before AW
        awDelay = 2; wDelay = 0;
        runRequest(1, 32'h8000_0002, 2'd0, 4'b0100, 32'h00AB_0000, 32'h0, 0);
        awDelay = 0;

        // Half read completing under a 4-cycle global freeze, then a read with
        // AR and R wait states to show the block went back to IDLE
        runRequest(0, 32'h0000_1006, 2'd1, 4'b0000, 32'h0, 32'h1234_5678, 4);
        arDelay = 1; rDelay = 2;
        runRequest(0, 32'h0000_2000, 2'd2, 4'b0000, 32'h0, 32'hCAFE_F00D, 0);
        arDelay = 0; rDelay = 0;

        // Back-to-back write (slow B) then read
        bDelay = 5;
        runRequest(1, 32'h0000_3000, 2'd2, 4'b1111, 32'h5555_AAAA, 32'h0, 0);
        bDelay = 0;
        runRequest(0, 32'h0000_3000, 2'd2, 4'b0000, 32'h0, 32'h0BAD_CAFE, 0);
        assertEqual("arAfterB", 32'(arStartCycle > bHsCycle), 1);

        // Reset while waiting in RD_DATA
        rDelay = 20;
        rdataResp = 32'h7777_7777;
        mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h1000_0040;
        waitCnt = 0;
        @(negedge clk);
        while (!rready && waitCnt < 20) begin
            waitCnt++;
            @(negedge clk);
        end
        assertEqual("reachRdData", 32'(rready), 1);
        #2;
        rst = 1'b1;
        mem_en = 1'b0;
        #1;
        assertEqual("midRstArvalid", 32'(arvalid), 0);
        assertEqual("midRstRready", 32'(rready), 0);
        assertEqual("midRstStall", 32'(stall_from_mem), 0);
        assertEqual("midRstRdata", mem_rdata, 0);
        modelRdata = '0;
        rDelay = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        runRequest(0, 32'h1000_0080, 2'd2, 4'b0000, 32'h0, 32'h0F0F_1234, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        nFail++;
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/data_axi_responder.md
Name: data_axi_responder

Overview:
- Responder for the CPU memory-stage SRAM-like data request: datapath drives mem_en/addr/wdata/byte-enables, this block returns read data and a stall.
- Converts each request into one single-beat AXI read or write and holds the pipeline (stall_from_mem) until the transaction completes.
- Sits between the datapath memory stage and the SoC AXI interconnect; the instruction side uses a separate instance with the ID parameter changed.

Parameters:
- AXI_ID, 4'b0001, fixed arid/awid/wid value.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_en  in  1  request valid; already masked by exception flush.
- mem_wen  in  4  byte enables; nonzero = write, zero = read.
- mem_size  in  2  0 byte, 1 half, 2 word.
- mem_addr  in  ADDR_W  request address.
- mem_wdata  in  DATA_W  write data, already lane-aligned.
- longest_stall  in  1  global pipeline freeze from hazard unit.
- mem_rdata  out  DATA_W  read result, registered.
- stall_from_mem  out  1  request in progress.
- arid/araddr/arlen[7:0]/arsize[2:0]/arvalid  out; arready  in.
- rid/rdata/rresp[1:0]/rlast/rvalid  in; rready  out.
- awid/awaddr/awlen[7:0]/awsize[2:0]/awvalid  out; awready  in.
- wid/wdata/wstrb[3:0]/wlast/wvalid  out; wready  in.
- bid/bresp[1:0]/bvalid  in; bready  out.

Behaviour:
- Reset (async, rst=1): state IDLE; all valids/readys 0; mem_rdata 0; latched address/data/size 0; stall_from_mem 0.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - mem_en=1 & mem_wen=0 -> latch addr/size, go RD_ADDR.
  - mem_en=1 & mem_wen!=0 -> latch addr/size/wdata/wen, go WR_REQ.
  - mem_en=0 -> stay IDLE.
- stall_from_mem = (IDLE & mem_en) | (state not in {IDLE, DONE}); combinational, so the pipeline freezes in the request cycle.
- RD_ADDR: arvalid=1 with latched fields; arready=1 -> RD_DATA.
- RD_DATA: rready=1; rvalid=1 -> capture rdata into mem_rdata, go DONE.
- WR_REQ:
  - awvalid and wvalid both asserted from entry; each drops independently on its handshake (aw_done/w_done flags).
  - Once both done -> WR_RESP; same-cycle handshakes are legal.
- WR_RESP: bready=1; bvalid=1 -> DONE.
- DONE: stall_from_mem=0.
  - longest_stall=1 -> stay DONE; the same request is still presented and must not be reissued.
  - longest_stall=0 -> IDLE; the pipeline advances this cycle and the next request is seen next cycle.
- Fixed fields: arlen=awlen=0, wlast=1, arsize/awsize={1'b0,mem_size}, wstrb=latched mem_wen. Address passed unmodified (byte address kept).
- Once issued, a transaction runs to completion even if mem_en drops or an exception flush occurs.
- rresp/bresp/rid/bid/rlast ignored; no bus-error exception.
- mem_rdata holds its value until the next read completes; writes do not change it.
- Reset mid-transaction returns to IDLE immediately; the interconnect shares the same reset.
- Latency, zero-wait slave:
  - read: request cycle, AR cycle, R cycle -> stall 3 cycles, data valid in DONE.
  - write: request cycle, AW/W cycle, B cycle -> stall 3 cycles.

Decomposition:
- Shared package axi_defs: state encoding localparams, AXI_SIZE_BYTE/HALF/WORD, AXI_BURST_INCR, AXI_ID_INST=4'b0000, AXI_ID_DATA=4'b0001.
- No sub-module: a single FSM plus the aw_done/w_done flags is cleaner inline.

Test Plan:
- Word read at 0xBFC0_0100, slave returns 0xDEAD_BEEF with arready/rvalid immediate -> stall_from_mem high 3 cycles, araddr=0xBFC0_0100, arsize=2, mem_rdata=0xDEAD_BEEF in DONE.
- Byte write mem_wen=4'b0100, addr 0x8000_0002, wdata 0x00AB_0000; wready 2 cycles before awready -> one AW, one W, wstrb=4'b0100, awsize=0, single B, then DONE.
- Read completes while longest_stall=1 for 4 cycles -> stays DONE, no second arvalid, mem_rdata stable; IDLE the cycle after longest_stall falls.
- Back-to-back write then read with bvalid delayed 5 cycles -> stall held through WR_RESP; read AR issued only after B handshake.
- rst asserted in RD_DATA -> arvalid/rready/stall_from_mem 0 and mem_rdata 0 asynchronously; next mem_en starts a fresh AR.
- mem_en=0 for 10 cycles -> no AXI valids, stall_from_mem 0.
